// File: rtl/ti_sbox_stream_pkg.sv
// Shared types and sizing constants for the streaming threshold S-box wrapper.
package ti_sbox_stream_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  localparam int NSHARES  = 3;
  localparam int NRAND    = 2;
  localparam int IN_BYTES = NSHARES + NRAND;

endpackage

// File: rtl/sbox_ti.sv
// Three-share S-box core: out1^out2^out3 == SBOX(in1^in2^in3), CORE_LAT register stages.
module sbox_ti #(
  parameter int CORE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] R0,
  input  logic [7:0] R1,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // GF(2^8) inverse as x^254 = x^2 * x^4 * ... * x^128, then the AES affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] sbox_val;
  logic [CORE_LAT-1:0][7:0] p1, p2, p3;

  assign sbox_val = aes_sbox(in1 ^ in2 ^ in3);

  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      p1[0] <= sbox_val ^ R0 ^ R1;
      p2[0] <= R0 ^ in2;
      p3[0] <= R1 ^ in2;
      for (int i = 1; i < CORE_LAT; i++) begin
        p1[i] <= p1[i-1];
        p2[i] <= p2[i-1];
        p3[i] <= p3[i-1];
      end
    end
  end

  assign out1 = p1[CORE_LAT-1];
  assign out2 = p2[CORE_LAT-1];
  assign out3 = p3[CORE_LAT-1];

endmodule

// File: rtl/ti_sbox_stream.sv
// Byte-stream wrapper around sbox_ti: loads shares+randomness, waits, unloads shares or recombined byte.
// state  | meaning
// LOAD   | accepting operand bytes 0..4 (share1..3, R0, R1)
// WAIT   | operands stable, CORE_LAT+1 cycles for the core
// UNLOAD | presenting result bytes until the out_last handshake
module ti_sbox_stream
  import ti_sbox_stream_pkg::*;
#(
  parameter int CORE_LAT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             recombine,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int WAIT_W = $clog2(CORE_LAT + 2);

  state_t state, state_nxt;
  logic [2:0]                 byte_idx;
  logic [1:0]                 out_idx;
  logic [WAIT_W-1:0]          wait_cnt;
  logic [IN_BYTES-1:0][7:0]   opnd;
  logic [NSHARES-1:0][7:0]    res;
  logic                       recomb_q;
  logic [7:0]                 core_o1, core_o2, core_o3;
  logic                       in_hs, out_hs, last_byte, wait_done;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_byte = (byte_idx == 3'(IN_BYTES - 1));
  assign wait_done = (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_hs && last_byte) state_nxt = WAIT;
      WAIT:    if (wait_done)          state_nxt = UNLOAD;
      UNLOAD:  if (out_hs && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == UNLOAD);
    busy      = (state != LOAD) || (byte_idx != 3'd0);
    out_last  = out_valid && (recomb_q || (out_idx == 2'(NSHARES - 1)));
    out_data  = 8'h00;
    if (out_valid) begin
      if (recomb_q) out_data = res[0] ^ res[1] ^ res[2];
      else begin
        case (out_idx)
          2'd0:    out_data = res[0];
          2'd1:    out_data = res[1];
          default: out_data = res[2];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx  <= 3'd0;
      out_idx   <= 2'd0;
      wait_cnt  <= '0;
      opnd      <= '0;
      res       <= '0;
      recomb_q  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (in_hs) begin
        opnd[byte_idx] <= in_data;
        byte_idx       <= last_byte ? 3'd0 : byte_idx + 3'd1;
        if (byte_idx == 3'd0) recomb_q <= recombine;
      end
      if (in_hs && last_byte)          wait_cnt <= WAIT_W'(CORE_LAT);
      else if (state == WAIT && !wait_done) wait_cnt <= wait_cnt - 1'b1;
      if (state == WAIT && wait_done) begin
        res     <= {core_o3, core_o2, core_o1};
        out_idx <= 2'd0;
      end
      if (out_hs) begin
        if (out_last) begin
          out_idx   <= 2'd0;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          out_idx <= out_idx + 2'd1;
        end
      end
    end
  end

  sbox_ti #(.CORE_LAT(CORE_LAT)) u_core (
    .clk  (clk),
    .rst  (reset),
    .in1  (opnd[0]),
    .in2  (opnd[1]),
    .in3  (opnd[2]),
    .R0   (opnd[3]),
    .R1   (opnd[4]),
    .out1 (core_o1),
    .out2 (core_o2),
    .out3 (core_o3)
  );

endmodule

// File: tb/tb_ti_sbox_stream.sv
// Directed bench for ti_sbox_stream; expected S-box values are hand-taken from the AES table.
module tb_ti_sbox_stream;

  localparam int CORE_LAT = 2;
  localparam int CNT_W    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             recombine = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  ti_sbox_stream #(.CORE_LAT(CORE_LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .recombine (recombine),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks are entered and left just after a falling edge.
  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; recombine = 1'b0; out_ready = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_frame(input logic [7:0] s1, s2, s3, r0, r1, input logic rec, input bit gaps);
    logic [7:0] v [5];
    int g;
    v[0] = s1; v[1] = s2; v[2] = s3; v[3] = r0; v[4] = r1;
    for (int i = 0; i < 5; i++) begin
      if (gaps) begin
        g = $urandom_range(1, 3);
        repeat (g) begin
          in_valid = 1'b0; in_data = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid  = 1'b1;
      in_data   = v[i];
      recombine = (gaps && i > 0) ? ~rec : rec;
      @(negedge clk);
    end
    in_valid = gaps;
    in_data  = 8'hEE;
  endtask

  task automatic wait_out(output int k);
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic collect(output logic [3:0][7:0] d, output logic [3:0] l, output int n,
                         output bit timeout, output int bad_last);
    int cyc;
    bit done;
    d = '0; l = '0; n = 0; timeout = 0; bad_last = 0; cyc = 0; done = 0;
    while (!done) begin
      out_ready = 1'b1;
      if (!out_valid && out_last) bad_last++;
      if (out_valid) begin
        if (n < 4) begin d[n] = out_data; l[n] = out_last; end
        n++;
        if (out_last) done = 1;
      end
      @(negedge clk);
      cyc++;
      if (!done && cyc > 40) begin timeout = 1; done = 1; end
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_basic();
    logic [3:0][7:0] d; logic [3:0] l; int n, k, bl; bit to;
    load_frame(8'h12, 8'h34, 8'h56, 8'hA5, 8'h3C, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_wait_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL basic_wait_busy: got %b want 1", busy); end
    wait_out(k);
    checks++; if (k != CORE_LAT + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", k, CORE_LAT + 2); end
    collect(d, l, n, to, bl);
    checks++; if (to || n != 3) begin errors++; $display("FAIL basic_count: got %0d bytes (timeout %0d) want 3", n, to); end
    checks++; if ((d[0] ^ d[1] ^ d[2]) !== 8'h51) begin errors++; $display("FAIL basic_xor: got %h want 51", d[0] ^ d[1] ^ d[2]); end
    checks++; if (l[2:0] !== 3'b100) begin errors++; $display("FAIL basic_last: got %b want 100", l[2:0]); end
    checks++; if (bl != 0) begin errors++; $display("FAIL basic_last_no_valid: got %0d want 0", bl); end
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_back_to_load: got valid %b last %b ready %b want 0 0 1", out_valid, out_last, in_ready);
    end
  endtask

  task automatic test_recombine();
    logic [3:0][7:0] d; logic [3:0] l; int n, k, bl; bit to;
    load_frame(8'h12, 8'h34, 8'h56, 8'hA5, 8'h3C, 1'b1, 1'b0);
    wait_out(k);
    checks++; if (k != CORE_LAT + 2) begin errors++; $display("FAIL recomb_latency: got %0d want %0d", k, CORE_LAT + 2); end
    collect(d, l, n, to, bl);
    checks++; if (to || n != 1) begin errors++; $display("FAIL recomb_count: got %0d bytes want 1", n); end
    checks++; if (d[0] !== 8'h51 || l[0] !== 1'b1) begin errors++; $display("FAIL recomb_byte: got %h last %b want 51 last 1", d[0], l[0]); end
    checks++; if (frame_cnt !== 2'd2) begin errors++; $display("FAIL recomb_frame_cnt: got %0d want 2", frame_cnt); end
    load_frame(8'h12, 8'h34, 8'h56, 8'hFF, 8'h00, 1'b1, 1'b0);
    wait_out(k);
    collect(d, l, n, to, bl);
    checks++; if (to || n != 1 || d[0] !== 8'h51) begin errors++; $display("FAIL recomb_rand_ff00: got %h (%0d bytes) want 51", d[0], n); end
    checks++; if (frame_cnt !== 2'd3) begin errors++; $display("FAIL recomb_frame_cnt2: got %0d want 3", frame_cnt); end
  endtask

  task automatic test_backpressure();
    logic [3:0][7:0] d; logic [3:0] l; logic [7:0] held_d; logic held_l;
    int n, k, cyc; bit done, stalled;
    load_frame(8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 1'b0, 1'b0);
    wait_out(k);
    checks++; if (k != CORE_LAT + 2) begin errors++; $display("FAIL bp_latency: got %0d want %0d", k, CORE_LAT + 2); end
    d = '0; l = '0; n = 0; cyc = 0; done = 0; stalled = 0; held_d = 8'h00; held_l = 1'b0;
    while (!done && cyc < 80) begin
      out_ready = (cyc < 10) ? 1'b0 : ((cyc - 10) % 2 == 0);
      if (stalled) begin
        checks++;
        if (out_data !== held_d || out_last !== held_l) begin
          errors++; $display("FAIL bp_hold: got %h/%b want %h/%b", out_data, out_last, held_d, held_l);
        end
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      stalled = 0;
      if (out_valid && out_ready) begin
        if (n < 4) begin d[n] = out_data; l[n] = out_last; end
        n++;
        if (out_last) done = 1;
      end else if (out_valid) begin
        stalled = 1; held_d = out_data; held_l = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    checks++; if (!done || n != 3) begin errors++; $display("FAIL bp_count: got %0d bytes done %0d want 3", n, done); end
    checks++; if ((d[0] ^ d[1] ^ d[2]) !== 8'h7C) begin errors++; $display("FAIL bp_xor: got %h want 7c", d[0] ^ d[1] ^ d[2]); end
    checks++; if (l[2:0] !== 3'b100) begin errors++; $display("FAIL bp_last: got %b want 100", l[2:0]); end
    checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL bp_frame_cnt_wrap: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_gapped();
    logic [3:0][7:0] d; logic [3:0] l; int n, k, bl; bit to;
    load_frame(8'h50, 8'h02, 8'h01, 8'h77, 8'h88, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gap_wait_in_ready: got %b want 0", in_ready); end
    wait_out(k);
    checks++; if (k != CORE_LAT + 2) begin errors++; $display("FAIL gap_latency: got %0d want %0d", k, CORE_LAT + 2); end
    collect(d, l, n, to, bl);
    in_valid = 1'b0;
    checks++; if (to || n != 3) begin errors++; $display("FAIL gap_count: got %0d bytes want 3", n); end
    checks++; if ((d[0] ^ d[1] ^ d[2]) !== 8'hED) begin errors++; $display("FAIL gap_xor: got %h want ed", d[0] ^ d[1] ^ d[2]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_junk_ignored_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL gap_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [3:0][7:0] d; logic [3:0] l; int n, k, bl; bit to;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hFF; recombine = 1'b1;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_partial_busy: got %b want 1", busy); end
    do_reset(1);
    checks++; if (busy !== 1'b0 || frame_cnt !== 2'd0) begin
      errors++; $display("FAIL rmid_after_reset: got busy %b cnt %0d want 0 0", busy, frame_cnt);
    end
    load_frame(8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3, 1'b0, 1'b0);
    wait_out(k);
    collect(d, l, n, to, bl);
    checks++; if (to || n != 3) begin errors++; $display("FAIL rmid_count: got %0d bytes want 3", n); end
    checks++; if ((d[0] ^ d[1] ^ d[2]) !== 8'h63) begin errors++; $display("FAIL rmid_xor: got %h want 63", d[0] ^ d[1] ^ d[2]); end
    checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL rmid_frame_cnt: got %0d want 1", frame_cnt); end
    load_frame(8'h11, 8'h00, 8'h00, 8'h01, 8'h02, 1'b1, 1'b0);
    wait_out(k);
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL runl_pending: got %b want 1", out_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
      errors++; $display("FAIL runl_outputs: got valid %b data %h last %b want 0 00 0", out_valid, out_data, out_last);
    end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 2'd0) begin
      errors++; $display("FAIL runl_state: got busy %b ready %b cnt %0d want 0 1 0", busy, in_ready, frame_cnt);
    end
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_wrap();
    logic [3:0][7:0] d; logic [3:0] l; int n, k, bl; bit to;
    logic [7:0] xs   [5];
    logic [7:0] sb   [5];
    logic [1:0] cnts [5];
    xs[0] = 8'h00; sb[0] = 8'h63; cnts[0] = 2'd1;
    xs[1] = 8'h01; sb[1] = 8'h7C; cnts[1] = 2'd2;
    xs[2] = 8'h10; sb[2] = 8'hCA; cnts[2] = 2'd3;
    xs[3] = 8'h11; sb[3] = 8'h82; cnts[3] = 2'd0;
    xs[4] = 8'hFF; sb[4] = 8'h16; cnts[4] = 2'd1;
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      load_frame(xs[i] ^ 8'h3A, 8'h3A ^ 8'hC5, 8'hC5, 8'(i * 37), 8'(8'h90 + i), 1'b1, 1'b0);
      wait_out(k);
      collect(d, l, n, to, bl);
      checks++; if (to || n != 1 || d[0] !== sb[i]) begin
        errors++; $display("FAIL wrap_data%0d: got %h (%0d bytes) want %h", i, d[0], n, sb[i]);
      end
      checks++; if (frame_cnt !== cnts[i]) begin
        errors++; $display("FAIL wrap_cnt%0d: got %0d want %0d", i, frame_cnt, cnts[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_recombine();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ti_sbox_stream.md
TI_SBOX_STREAM -- requirements
Module: ti_sbox_stream

Interface
REQ-001 Parameter CORE_LAT, default 2: clock cycles from a stable operand set on the sbox_ti inputs to valid sbox_ti outputs.
REQ-002 Parameter CNT_W, default 8: width of frame_cnt.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid operand byte.
REQ-006 in_ready  output  1  block accepts a byte this cycle.
REQ-007 in_data  input  8  operand byte.
REQ-008 recombine  input  1  mode select, sampled on the first byte handshake of a frame: 0 = output three shares, 1 = output one unmasked byte.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  8  result byte.
REQ-012 out_last  output  1  marks the final byte of a result frame.
REQ-013 busy  output  1  high in any state other than LOAD with zero bytes held.
REQ-014 frame_cnt  output  CNT_W  count of completed result frames, wraps modulo 2^CNT_W.

Function
REQ-015 A handshake occurs on a cycle with valid and ready both high; no other cycle transfers data.
REQ-016 FSM states: LOAD, WAIT, UNLOAD; the FSM enters LOAD on reset.
REQ-017 LOAD: in_ready=1 and out_valid=0; each input handshake stores in_data at byte index 0..4, in order: share1, share2, share3, R0, R1.
REQ-018 The 5th handshake moves the FSM LOAD->WAIT; in WAIT and UNLOAD, in_ready=0 and in_valid is ignored.
REQ-019 The operand register drives sbox_ti directly and holds stable from the end of LOAD until the FSM re-enters LOAD.
REQ-020 WAIT lasts exactly CORE_LAT+1 cycles, then the block captures the sbox_ti outputs o1/o2/o3 into the result register and moves WAIT->UNLOAD.
REQ-021 Latency: out_valid first rises CORE_LAT+2 cycles after the cycle of the 5th input handshake, independent of out_ready.
REQ-022 UNLOAD with recombine=0: the block emits o1, o2, o3 in that order, with out_last on o3.
REQ-023 UNLOAD with recombine=1: the block emits the single byte o1^o2^o3 with out_last=1.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_last hold unchanged (back-pressure of any length).
REQ-025 The handshake on the out_last byte moves the FSM UNLOAD->LOAD and increments frame_cnt by 1, wrapping 2^CNT_W-1 -> 0.
REQ-026 The block accepts the first byte of the next frame no earlier than the cycle after the out_last handshake; frames never overlap.
REQ-027 A change on recombine after the first byte of a frame has no effect on that frame.
REQ-028 out_last=0 whenever out_valid=0.

Reset
REQ-029 Reset overrides every other input in the same cycle.
REQ-030 Reset values: FSM=LOAD, byte index=0, operand and result registers=0, in_ready=1 from the first cycle after reset, out_valid=0, out_data=0, out_last=0, busy=0, frame_cnt=0.
REQ-031 Reset in any state aborts the frame: partial input is discarded, pending output is dropped, frame_cnt is not incremented.
REQ-032 sbox_ti rst is driven by reset.

Structure
REQ-033 A shared package holds the FSM state enumeration, the constant NSHARES=3, the constant NRAND=2, and the constant IN_BYTES=NSHARES+NRAND=5.
REQ-034 The design contains exactly one sub-module instance: the existing three-share threshold S-box core sbox_ti (in1, in2, in3, R0, R1 -> out1, out2, out3).
REQ-035 All remaining logic is local: byte index, WAIT counter, output index, and registers.

Verification
REQ-036 The bench checks each frame with a golden model: o1^o2^o3 == SBOX(s1^s2^s3) for any R0/R1.
REQ-037 Scenario, basic: with out_ready=1 and recombine=0, feed 0x12,0x34,0x56,0xA5,0x3C on back-to-back cycles.
    - out_valid rises exactly CORE_LAT+2 cycles after the 5th byte.
    - Three consecutive bytes follow; their XOR equals SBOX(0x70); out_last is on byte 3; frame_cnt=1.
REQ-038 Scenario, recombine: same operands with recombine=1.
    - A single byte SBOX(0x70) appears with out_last=1.
    - Repeat with R0/R1=0xFF,0x00: the output byte is identical.
REQ-039 Scenario, back-pressure: hold out_ready=0 for 10 cycles in UNLOAD, then toggle it every cycle.
    - out_data is stable while stalled; no byte is lost or duplicated.
    - in_ready stays 0 throughout.
REQ-040 Scenario, gapped input: insert random in_valid gaps between the 5 bytes, and drive in_valid in WAIT/UNLOAD.
    - Only the 5 handshaked bytes form the frame.
    - Bytes driven in WAIT/UNLOAD are ignored.
REQ-041 Scenario, reset mid-operation: reset after byte 3 of frame A, then send full frame B.
    - Frame B's result is correct and frame_cnt=1.
    - Repeat with reset asserted during UNLOAD: all outputs are 0 the next cycle.
REQ-042 Scenario, wrap: with CNT_W=2, run 5 frames; frame_cnt reads 1,2,3,0,1.
